// File: rtl/spi_xfer_sequencer.sv
// APB master that drives a CoreSPI instance as a byte-transfer engine: select slave, push/pull
// cmd_len bytes one at a time through STAT polling, deselect, pulse done.
module spi_xfer_sequencer #(
   parameter logic [6:0] ADDR_CTRL1  = 7'h00,
   parameter logic [6:0] ADDR_RXDATA = 7'h08,
   parameter logic [6:0] ADDR_TXDATA = 7'h0C,
   parameter logic [6:0] ADDR_STAT   = 7'h20,
   parameter logic [6:0] ADDR_SSEL   = 7'h24,
   parameter int         LEN_W       = 8,
   parameter int         POLL_MAX    = 1024
) (
   input  logic             PCLK,
   input  logic             PRESETN,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [7:0]       cmd_ssel,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic [7:0]       tx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic [7:0]       rx_data,
   output logic             busy,
   output logic             done,
   output logic             err_timeout,
   output logic             PSEL,
   output logic             PENABLE,
   output logic             PWRITE,
   output logic [6:0]       PADDR,
   output logic [31:0]      PWDATA,
   input  logic [31:0]      PRDATA,
   input  logic             PREADY,
   input  logic             PSLVERR
);
   typedef enum logic [3:0] {S_INIT, S_IDLE, S_SSEL_ON, S_WAIT_TX, S_PUSH, S_WAIT_RX,
                             S_POP, S_HOLD_RX, S_SSEL_OFF, S_DONE} state_t;
   typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS} apb_t;
   localparam int PW = $clog2(POLL_MAX + 1);

   state_t           state, state_d;
   apb_t             aph;
   logic [7:0]       ssel_q;
   logic [LEN_W-1:0] len_q, byte_cnt, cnt_inc;
   logic [PW-1:0]    poll_cnt;
   logic             apb_idle, apb_done, apb_start, apb_wr;
   logic [6:0]       apb_addr;
   logic [31:0]      apb_wdata;
   logic             load_cmd, rx_load, rx_take, set_err, poll_inc, last_byte, poll_to;
   logic             unused_prdata;

   assign unused_prdata = ^PRDATA[31:8];
   assign apb_idle  = (aph == A_IDLE);
   assign apb_done  = (aph == A_ACCESS) && PREADY;
   assign PSEL      = !apb_idle;
   assign PENABLE   = (aph == A_ACCESS);
   assign cnt_inc   = byte_cnt + 1'b1;
   assign last_byte = (cnt_inc == ((len_q == '0) ? LEN_W'(1) : len_q));
   assign poll_to   = (poll_cnt == PW'(POLL_MAX - 1));

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) state <= S_INIT;
      else          state <= state_d;
   end

   always_comb begin
      state_d   = state;
      apb_start = 1'b0;
      apb_wr    = 1'b0;
      apb_addr  = ADDR_STAT;
      apb_wdata = 32'h0;
      cmd_ready = 1'b0;
      tx_ready  = 1'b0;
      done      = 1'b0;
      load_cmd  = 1'b0;
      rx_load   = 1'b0;
      rx_take   = 1'b0;
      set_err   = 1'b0;
      poll_inc  = 1'b0;
      case (state)
         S_INIT: begin
            apb_start = apb_idle;
            apb_wr    = 1'b1;
            apb_addr  = ADDR_CTRL1;
            apb_wdata = 32'h3;
            if (apb_done) state_d = S_IDLE;
         end
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               load_cmd = 1'b1;
               state_d  = S_SSEL_ON;
            end
         end
         S_SSEL_ON: begin
            apb_start = apb_idle;
            apb_wr    = 1'b1;
            apb_addr  = ADDR_SSEL;
            apb_wdata = {24'h0, ssel_q};
            if (apb_done) state_d = S_WAIT_TX;
         end
         S_WAIT_TX: begin
            apb_start = apb_idle && tx_valid;
            if (apb_done) begin
               if (!PRDATA[3])   state_d = S_PUSH;
               else if (poll_to) begin set_err = 1'b1; state_d = S_SSEL_OFF; end
               else              poll_inc = 1'b1;
            end
         end
         S_PUSH: begin
            // the byte is taken on the same cycle the TXDATA write is launched
            tx_ready  = apb_idle && tx_valid;
            apb_start = tx_ready;
            apb_wr    = 1'b1;
            apb_addr  = ADDR_TXDATA;
            apb_wdata = {24'h0, tx_data};
            if (apb_done) state_d = S_WAIT_RX;
         end
         S_WAIT_RX: begin
            apb_start = apb_idle;
            if (apb_done) begin
               if (!PRDATA[2])   state_d = S_POP;
               else if (poll_to) begin set_err = 1'b1; state_d = S_SSEL_OFF; end
               else              poll_inc = 1'b1;
            end
         end
         S_POP: begin
            apb_start = apb_idle;
            apb_addr  = ADDR_RXDATA;
            if (apb_done) begin
               rx_load = 1'b1;
               state_d = S_HOLD_RX;
            end
         end
         S_HOLD_RX: begin
            if (rx_ready) begin
               rx_take = 1'b1;
               state_d = last_byte ? S_SSEL_OFF : S_WAIT_TX;
            end
         end
         S_SSEL_OFF: begin
            apb_start = apb_idle;
            apb_wr    = 1'b1;
            apb_addr  = ADDR_SSEL;
            if (apb_done) state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_INIT;
      endcase
      // slave error aborts like a timeout; deselect still runs
      if (apb_done && PSLVERR) begin
         set_err  = 1'b1;
         rx_load  = 1'b0;
         poll_inc = 1'b0;
         if (state == S_INIT)          state_d = S_IDLE;
         else if (state == S_SSEL_OFF) state_d = S_DONE;
         else                          state_d = S_SSEL_OFF;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         aph         <= A_IDLE;
         PWRITE      <= 1'b0;
         PADDR       <= 7'h0;
         PWDATA      <= 32'h0;
         ssel_q      <= 8'h0;
         len_q       <= '0;
         byte_cnt    <= '0;
         poll_cnt    <= '0;
         rx_valid    <= 1'b0;
         rx_data     <= 8'h0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         case (aph)
            A_IDLE:   if (apb_start) aph <= A_SETUP;
            A_SETUP:  aph <= A_ACCESS;
            A_ACCESS: if (PREADY) aph <= A_IDLE;
            default:  aph <= A_IDLE;
         endcase
         if (apb_start) begin
            PWRITE <= apb_wr;
            PADDR  <= apb_addr;
            PWDATA <= apb_wdata;
         end
         if (load_cmd) begin
            ssel_q   <= cmd_ssel;
            len_q    <= cmd_len;
            byte_cnt <= '0;
         end else if (rx_take) begin
            byte_cnt <= cnt_inc;
         end
         if (poll_inc)              poll_cnt <= poll_cnt + 1'b1;
         else if (state_d != state) poll_cnt <= '0;
         if (rx_load) begin
            rx_valid <= 1'b1;
            rx_data  <= PRDATA[7:0];
         end else if (rx_take) begin
            rx_valid <= 1'b0;
         end
         if (load_cmd)               busy <= 1'b1;
         else if (state_d == S_DONE) busy <= 1'b0;
         if (load_cmd)     err_timeout <= 1'b0;
         else if (set_err) err_timeout <= 1'b1;
      end
   end
endmodule
